hamming_secded_stream_decoder: RTL and testbench

HAMMING_SECDED_STREAM_DECODER -- requirements
Module: hamming_secded_stream_decoder

---
 rtl/hamming_secded_stream_decoder.sv | 133 +++++++++++++
 tb/tb_hamming_secded_stream_decoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_stream_decoder.sv
// Serial Hamming SECDED frame decoder: collects L = 2^M bits (overall parity first),
// corrects single errors, flags double errors, and presents the data word on a valid/ready port.
module hamming_secded_stream_decoder #(
    parameter int unsigned M = 3,
    localparam int unsigned N = 2 ** M - 1,
    localparam int unsigned K = N - M,
    localparam int unsigned L = N + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         in_bit,
    input  logic         in_sof,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] out_data,
    output logic         out_corrected,
    output logic         out_uncorrectable,
    output logic [M-1:0] out_err_pos
);

    typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

    state_e         state_q;
    logic [L-1:0]   frame_q;
    logic [M-1:0]   cnt_q;

    logic           accept;
    logic           drain;
    logic           out_free;
    logic           last_bit;
    logic           load;
    logic [L-1:0]   dec_frame;
    logic [L-1:0]   fixed;
    logic [M-1:0]   syn;
    logic           par;
    logic [K-1:0]   dec_data;

    // Frame position of the j-th data bit (positions that are not powers of two).
    function automatic int unsigned data_pos(input int unsigned j);
        int unsigned seen;
        seen = 0;
        data_pos = 0;
        for (int unsigned i = 1; i < L; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (seen == j) data_pos = i;
                seen++;
            end
        end
    endfunction

    assign in_ready = (state_q != StHold);
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;
    assign out_free = ~out_valid | out_ready;
    assign last_bit = accept & ~in_sof & (state_q == StCollect) & (cnt_q == M'(L - 1));
    assign load     = (last_bit & out_free) | ((state_q == StHold) & drain);

    // Outside HOLD the final bit is still on in_bit, so decode straight from the input.
    always_comb begin
        dec_frame = frame_q;
        if (state_q != StHold) dec_frame[L-1] = in_bit;

        syn = '0;
        for (int unsigned i = 1; i < L; i++) begin
            if (dec_frame[i]) syn = syn ^ M'(i);
        end
        par = ^dec_frame;

        fixed = dec_frame;
        if (par) fixed[syn] = ~fixed[syn];

        dec_data = '0;
        for (int unsigned j = 0; j < K; j++) begin
            dec_data[j] = fixed[data_pos(j)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= StIdle;
            frame_q           <= '0;
            cnt_q             <= '0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_corrected     <= 1'b0;
            out_uncorrectable <= 1'b0;
            out_err_pos       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept && in_sof) begin
                        frame_q[0] <= in_bit;
                        cnt_q      <= M'(1);
                        state_q    <= StCollect;
                    end
                end
                StCollect: begin
                    if (accept) begin
                        if (in_sof) begin
                            frame_q[0] <= in_bit;
                            cnt_q      <= M'(1);
                        end else begin
                            frame_q[cnt_q] <= in_bit;
                            if (cnt_q == M'(L - 1)) begin
                                cnt_q   <= '0;
                                state_q <= out_free ? StIdle : StHold;
                            end else begin
                                cnt_q <= cnt_q + M'(1);
                            end
                        end
                    end
                end
                StHold: begin
                    if (drain) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            if (load) begin
                out_valid         <= 1'b1;
                out_data          <= dec_data;
                out_corrected     <= par;
                out_uncorrectable <= ~par & (syn != '0);
                out_err_pos       <= syn;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hamming_secded_stream_decoder.sv
// Directed + random bench for the SECDED stream decoder (M=3), with an output scoreboard.
module tb_hamming_secded_stream_decoder;

    localparam int unsigned M = 3;
    localparam int unsigned K = 4;
    localparam int unsigned L = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_bit;
    logic         in_sof;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [K-1:0] out_data;
    logic         out_corrected;
    logic         out_uncorrectable;
    logic [M-1:0] out_err_pos;

    hamming_secded_stream_decoder #(.M(M)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_bit           (in_bit),
        .in_sof           (in_sof),
        .in_ready         (in_ready),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_corrected    (out_corrected),
        .out_uncorrectable(out_uncorrectable),
        .out_err_pos      (out_err_pos)
    );

    typedef struct packed {
        logic [3:0] data;
        logic       corr;
        logic       unc;
        logic [2:0] pos;
    } exp_t;

    exp_t sb[$];
    int   check_cnt = 0;
    int   pass_cnt  = 0;
    int   out_cnt   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input logic [3:0] d, input logic c, input logic u,
                                input logic [2:0] p);
        exp_t e;
        e.data = d;
        e.corr = c;
        e.unc  = u;
        e.pos  = p;
        return e;
    endfunction

    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] f;
        f    = '0;
        f[3] = d[0];
        f[5] = d[1];
        f[6] = d[2];
        f[7] = d[3];
        f[1] = f[3] ^ f[5] ^ f[7];
        f[2] = f[3] ^ f[6] ^ f[7];
        f[4] = f[5] ^ f[6] ^ f[7];
        f[0] = ^f[7:1];
        return f;
    endfunction

    function automatic logic [3:0] extract(input logic [7:0] f);
        return {f[7], f[6], f[5], f[3]};
    endfunction

    // Scoreboard: every completed handshake pops one expected word.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_corrected", 32'(out_corrected), 32'(e.corr));
                chk("out_uncorrectable", 32'(out_uncorrectable), 32'(e.unc));
                chk("out_err_pos", 32'(out_err_pos), 32'(e.pos));
                out_cnt++;
            end
        end
    end

    task automatic send_bit(input logic b, input logic sof);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_bit   = b;
        in_sof   = sof;
        while (!in_ready && w < 40) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f, input logic push, input exp_t e);
        if (push) sb.push_back(e);
        for (int i = 0; i < 8; i++) send_bit(f[i], i == 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_corr"}, 32'(out_corrected), 32'd0);
        chk({tag, "_unc"}, 32'(out_uncorrectable), 32'd0);
        chk({tag, "_err_pos"}, 32'(out_err_pos), 32'd0);
    endtask

    initial begin
        logic [7:0] clean;
        logic [7:0] fa;
        logic [7:0] fb;
        logic [7:0] g;
        logic [3:0] d;
        int         t;
        int         e1;
        int         e2;

        clean     = 8'b1010_1010;
        fa        = encode(4'b0101);
        fb        = encode(4'b1110);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        #2;
        check_reset_outputs("reset");
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Clean frame, with one-cycle latency check.
        send_frame(clean, 1'b1, mk(4'b1011, 1'b0, 1'b0, 3'd0));
        chk("clean_latency_valid", 32'(out_valid), 32'd1);
        chk("clean_latency_data", 32'(out_data), 32'hb);
        idle(1);
        chk("valid_drops_after_xfer", 32'(out_valid), 32'd0);

        send_frame(clean ^ 8'b0010_0000, 1'b1, mk(4'b1011, 1'b1, 1'b0, 3'd5));
        send_frame(clean ^ 8'b0000_0001, 1'b1, mk(4'b1011, 1'b1, 1'b0, 3'd0));
        send_frame(clean ^ 8'b0110_0000, 1'b1, mk(4'b1101, 1'b0, 1'b1, 3'd3));
        idle(2);

        // Abort: partial frame restarted by in_sof at position 4, then stray bits in IDLE.
        g = encode(4'b0110);
        for (int i = 0; i < 4; i++) send_bit(g[i], i == 0);
        send_frame(clean, 1'b1, mk(4'b1011, 1'b0, 1'b0, 3'd0));
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        idle(4);
        chk("abort_sb_empty", 32'(sb.size()), 32'd0);
        chk("abort_no_output", 32'(out_valid), 32'd0);

        // Backpressure: second frame must park in HOLD.
        out_ready = 1'b0;
        send_frame(fa, 1'b1, mk(4'b0101, 1'b0, 1'b0, 3'd0));
        send_frame(fb, 1'b1, mk(4'b1110, 1'b0, 1'b0, 3'd0));
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        chk("hold_first_valid", 32'(out_valid), 32'd1);
        chk("hold_first_data", 32'(out_data), 32'h5);
        idle(3);
        chk("hold_stable_data", 32'(out_data), 32'h5);
        chk("hold_stable_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        idle(1);
        chk("hold_second_valid", 32'(out_valid), 32'd1);
        chk("hold_second_data", 32'(out_data), 32'he);
        chk("hold_in_ready_back", 32'(in_ready), 32'd1);
        idle(2);

        // Random frames with 0, 1 or 2 injected errors.
        for (int n = 0; n < 8; n++) begin
            d  = 4'($urandom_range(0, 15));
            t  = int'($urandom_range(0, 2));
            e1 = int'($urandom_range(0, 7));
            e2 = (e1 + int'($urandom_range(1, 7))) % 8;
            g  = encode(d);
            if (t == 0) begin
                send_frame(g, 1'b1, mk(d, 1'b0, 1'b0, 3'd0));
            end else if (t == 1) begin
                g[e1] = ~g[e1];
                send_frame(g, 1'b1, mk(d, 1'b1, 1'b0, 3'(e1)));
            end else begin
                g[e1] = ~g[e1];
                g[e2] = ~g[e2];
                send_frame(g, 1'b1, mk(extract(g), 1'b0, 1'b1, 3'(e1 ^ e2)));
            end
        end
        idle(3);

        // Reset during COLLECT; the tail of that frame arrives without in_sof.
        for (int i = 0; i < 3; i++) send_bit(clean[i], i == 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_collect");
        idle(1);
        rst_n = 1'b1;
        for (int i = 3; i < 8; i++) send_bit(clean[i], 1'b0);
        idle(3);
        chk("rst_collect_no_output", 32'(out_valid), 32'd0);

        // Reset during HOLD drops both the presented and the held word.
        out_ready = 1'b0;
        send_frame(fa, 1'b1, mk(4'b0101, 1'b0, 1'b0, 3'd0));
        send_frame(fb, 1'b1, mk(4'b1110, 1'b0, 1'b0, 3'd0));
        chk("rst_hold_entered", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_hold");
        sb.delete();
        idle(1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(4);
        chk("rst_hold_no_stale", 32'(out_valid), 32'd0);

        send_frame(clean ^ 8'b1000_0000, 1'b1, mk(4'b1011, 1'b1, 1'b0, 3'd7));
        idle(3);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        chk("final_out_count", 32'(out_cnt), 32'd16);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d",
                 check_cnt, pass_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
